// File: rtl/clause_array_vs_ls_lists.sv
// Bin storage for one SAT-engine bin: a clause array, a variable-state list
// and a level-state list. The bin manager loads and unloads them over wide
// buses with per-entry write enables. The core sees combinational reads and
// decoded per-entry fields.
module clause_array_vs_ls_lists #(
    parameter int NUM_CLAUSES      = 8,
    parameter int NUM_VARS         = 8,
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_BIN_ID     = 10,
    parameter int WIDTH_C_LEN      = 4,
    parameter int WIDTH_LVL        = 16,
    parameter int WIDTH_VAR_STATES = 19,
    parameter int WIDTH_LVL_STATES = 11
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 clear_i,
    input  logic [NUM_CLAUSES-1:0]               wr_carray_i,
    input  logic [2*NUM_VARS-1:0]                clause_i,
    input  logic [NUM_CLAUSES-1:0]               rd_carray_i,
    output logic [2*NUM_VARS-1:0]                clause_o,
    output logic [WIDTH_C_LEN*NUM_CLAUSES-1:0]   clause_len_o,
    input  logic [NUM_VARS-1:0]                  wr_var_states,
    input  logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_i,
    output logic [WIDTH_VAR_STATES*NUM_VARS-1:0] vars_states_o,
    output logic [2*NUM_VARS-1:0]                var_value_o,
    output logic [NUM_VARS-1:0]                  var_implied_o,
    output logic [NUM_VARS-1:0]                  var_assigned_o,
    input  logic [NUM_LVLS-1:0]                  wr_lvl_states,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_o,
    output logic [NUM_LVLS-1:0]                  lvl_has_bkt_o
);

    // Field positions inside a var-state entry: value, implied flag, level.
    localparam int VALUE_LSB   = 0;
    localparam int IMPLIED_BIT = 2;
    localparam int LEVEL_LSB   = 3;

    // The has-backtracked flag sits directly above the decided-bin id.
    localparam int HAS_BKT_BIT = WIDTH_BIN_ID;

    // Largest value the per-row length counter can show before saturating.
    localparam int MAX_LEN = (1 << WIDTH_C_LEN) - 1;

    // The entry widths are derived quantities; refuse inconsistent overrides.
    if (WIDTH_VAR_STATES != LEVEL_LSB + WIDTH_LVL) begin : g_bad_var_width
        $error("WIDTH_VAR_STATES must equal 3 + WIDTH_LVL");
    end
    if (WIDTH_LVL_STATES != WIDTH_BIN_ID + 1) begin : g_bad_lvl_width
        $error("WIDTH_LVL_STATES must equal WIDTH_BIN_ID + 1");
    end

    logic [2*NUM_VARS-1:0]         clause_mem [NUM_CLAUSES];
    logic [WIDTH_VAR_STATES-1:0]   var_mem    [NUM_VARS];
    logic [WIDTH_LVL_STATES-1:0]   lvl_mem    [NUM_LVLS];

    // Clause rows: clear beats writes; every enabled row takes the same clause.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NUM_CLAUSES; r++) begin
                clause_mem[r] <= '0;
            end
        end else if (clear_i) begin
            for (int r = 0; r < NUM_CLAUSES; r++) begin
                clause_mem[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_CLAUSES; r++) begin
                if (wr_carray_i[r]) begin
                    clause_mem[r] <= clause_i;
                end
            end
        end
    end

    // Var-state list: each enabled entry loads its own slice of the input bus.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NUM_VARS; j++) begin
                var_mem[j] <= '0;
            end
        end else if (clear_i) begin
            for (int j = 0; j < NUM_VARS; j++) begin
                var_mem[j] <= '0;
            end
        end else begin
            for (int j = 0; j < NUM_VARS; j++) begin
                if (wr_var_states[j]) begin
                    var_mem[j] <= vars_states_i[j*WIDTH_VAR_STATES +: WIDTH_VAR_STATES];
                end
            end
        end
    end

    // Level-state list: same slice-per-entry loading as the var states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_LVLS; k++) begin
                lvl_mem[k] <= '0;
            end
        end else if (clear_i) begin
            for (int k = 0; k < NUM_LVLS; k++) begin
                lvl_mem[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_LVLS; k++) begin
                if (wr_lvl_states[k]) begin
                    lvl_mem[k] <= lvl_states_i[k*WIDTH_LVL_STATES +: WIDTH_LVL_STATES];
                end
            end
        end
    end

    // Clause read port: OR together every selected row, zero when none selected.
    always_comb begin
        clause_o = '0;
        for (int r = 0; r < NUM_CLAUSES; r++) begin
            if (rd_carray_i[r]) begin
                clause_o = clause_o | clause_mem[r];
            end
        end
    end

    // Per-row literal count; reserved encodings count as present.
    always_comb begin
        int cnt;
        clause_len_o = '0;
        cnt = 0;
        for (int r = 0; r < NUM_CLAUSES; r++) begin
            cnt = 0;
            for (int i = 0; i < NUM_VARS; i++) begin
                if (clause_mem[r][2*i +: 2] != 2'b00) begin
                    cnt = cnt + 1;
                end
            end
            if (cnt > MAX_LEN) begin
                cnt = MAX_LEN;
            end
            clause_len_o[r*WIDTH_C_LEN +: WIDTH_C_LEN] = WIDTH_C_LEN'(cnt);
        end
    end

    // Var-state unload bus and decoded value/implied/assigned fields.
    always_comb begin
        vars_states_o  = '0;
        var_value_o    = '0;
        var_implied_o  = '0;
        var_assigned_o = '0;
        for (int j = 0; j < NUM_VARS; j++) begin
            vars_states_o[j*WIDTH_VAR_STATES +: WIDTH_VAR_STATES] = var_mem[j];
            var_value_o[2*j +: 2] = var_mem[j][VALUE_LSB +: 2];
            var_implied_o[j]      = var_mem[j][IMPLIED_BIT];
            var_assigned_o[j]     = (var_mem[j][VALUE_LSB +: 2] != 2'b00);
        end
    end

    // Level-state unload bus and decoded has-backtracked flags.
    always_comb begin
        lvl_states_o  = '0;
        lvl_has_bkt_o = '0;
        for (int k = 0; k < NUM_LVLS; k++) begin
            lvl_states_o[k*WIDTH_LVL_STATES +: WIDTH_LVL_STATES] = lvl_mem[k];
            lvl_has_bkt_o[k] = lvl_mem[k][HAS_BKT_BIT];
        end
    end

endmodule

// File: tb/tb_clause_array_vs_ls_lists.sv
// Directed bench for the bin storage block. Expected values are pushed to a
// scoreboard queue as each step is driven and popped when outputs are sampled.
module tb_clause_array_vs_ls_lists;

    localparam int NC  = 8;
    localparam int NV  = 8;
    localparam int NL  = 8;
    localparam int WCL = 4;
    localparam int WVS = 19;
    localparam int WLS = 11;

    // Output selectors used by scoreboard entries.
    localparam int SEL_CLAUSE  = 0;
    localparam int SEL_LEN     = 1;
    localparam int SEL_VARS    = 2;
    localparam int SEL_VALUE   = 3;
    localparam int SEL_IMPLIED = 4;
    localparam int SEL_ASSIGN  = 5;
    localparam int SEL_LVLS    = 6;
    localparam int SEL_HASBKT  = 7;

    typedef struct {
        string        tag;
        int           sel;
        logic [159:0] expected;
    } sb_item_t;

    logic                 clk;
    logic                 rst;
    logic                 clear_i;
    logic [NC-1:0]        wr_carray_i;
    logic [2*NV-1:0]      clause_i;
    logic [NC-1:0]        rd_carray_i;
    logic [2*NV-1:0]      clause_o;
    logic [WCL*NC-1:0]    clause_len_o;
    logic [NV-1:0]        wr_var_states;
    logic [WVS*NV-1:0]    vars_states_i;
    logic [WVS*NV-1:0]    vars_states_o;
    logic [2*NV-1:0]      var_value_o;
    logic [NV-1:0]        var_implied_o;
    logic [NV-1:0]        var_assigned_o;
    logic [NL-1:0]        wr_lvl_states;
    logic [WLS*NL-1:0]    lvl_states_i;
    logic [WLS*NL-1:0]    lvl_states_o;
    logic [NL-1:0]        lvl_has_bkt_o;

    sb_item_t sb_queue[$];
    int checks = 0;
    int errors = 0;

    clause_array_vs_ls_lists dut (
        .clk            (clk),
        .rst            (rst),
        .clear_i        (clear_i),
        .wr_carray_i    (wr_carray_i),
        .clause_i       (clause_i),
        .rd_carray_i    (rd_carray_i),
        .clause_o       (clause_o),
        .clause_len_o   (clause_len_o),
        .wr_var_states  (wr_var_states),
        .vars_states_i  (vars_states_i),
        .vars_states_o  (vars_states_o),
        .var_value_o    (var_value_o),
        .var_implied_o  (var_implied_o),
        .var_assigned_o (var_assigned_o),
        .wr_lvl_states  (wr_lvl_states),
        .lvl_states_i   (lvl_states_i),
        .lvl_states_o   (lvl_states_o),
        .lvl_has_bkt_o  (lvl_has_bkt_o)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [159:0] observe(int sel);
        case (sel)
            SEL_CLAUSE:  return 160'(clause_o);
            SEL_LEN:     return 160'(clause_len_o);
            SEL_VARS:    return 160'(vars_states_o);
            SEL_VALUE:   return 160'(var_value_o);
            SEL_IMPLIED: return 160'(var_implied_o);
            SEL_ASSIGN:  return 160'(var_assigned_o);
            SEL_LVLS:    return 160'(lvl_states_o);
            SEL_HASBKT:  return 160'(lvl_has_bkt_o);
            default:     return '1;
        endcase
    endfunction

    task automatic expectValue(input string tag, input int sel, input logic [159:0] value);
        sb_item_t item;
        item.tag      = tag;
        item.sel      = sel;
        item.expected = value;
        sb_queue.push_back(item);
    endtask

    // Pops every pending expectation and compares it with the live outputs.
    task automatic checkOutput();
        sb_item_t item;
        logic [159:0] obs;
        while (sb_queue.size() > 0) begin
            item = sb_queue.pop_front();
            obs  = observe(item.sel);
            checks++;
            assert (obs === item.expected)
            else begin
                errors++;
                $error("[TB] FAIL %s observed=%h expected=%h", item.tag, obs, item.expected);
            end
        end
    endtask

    task automatic applyStimulus(input logic [NC-1:0] wr_c, input logic [2*NV-1:0] cl,
                                 input logic [NC-1:0] rd_c, input logic [NV-1:0] wr_v,
                                 input logic [WVS*NV-1:0] vdata, input logic [NL-1:0] wr_l,
                                 input logic [WLS*NL-1:0] ldata, input logic clr);
        wr_carray_i   = wr_c;
        clause_i      = cl;
        rd_carray_i   = rd_c;
        wr_var_states = wr_v;
        vars_states_i = vdata;
        wr_lvl_states = wr_l;
        lvl_states_i  = ldata;
        clear_i       = clr;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idleInputs(input logic [NC-1:0] rd_c);
        applyStimulus('0, '0, rd_c, '0, '0, '0, '0, 1'b0);
    endtask

    initial begin
        logic [WVS*NV-1:0] vexp;
        logic [WVS*NV-1:0] vdata;
        logic [18:0]       ventry;
        logic [10:0]       lentry;
        logic [15:0]       row_vals [3];

        row_vals[0] = 16'h0012;
        row_vals[1] = 16'h0048;
        row_vals[2] = 16'h0220;
        ventry = 19'h15;
        lentry = 11'h405;

        // Reset state, checked while reset is held
        rst = 1'b1;
        applyStimulus('0, '0, 8'hff, '0, '0, '0, '0, 1'b0);
        #2;
        expectValue("reset_clause", SEL_CLAUSE, '0);
        expectValue("reset_len", SEL_LEN, '0);
        expectValue("reset_vars", SEL_VARS, '0);
        expectValue("reset_lvls", SEL_LVLS, '0);
        expectValue("reset_assigned", SEL_ASSIGN, '0);
        checkOutput();
        @(negedge clk);
        rst = 1'b0;

        // Clause load, one row per cycle
        for (int i = 0; i < 3; i++) begin
            applyStimulus(NC'(1 << i), row_vals[i], '0, '0, '0, '0, '0, 1'b0);
            tick();
        end
        idleInputs(8'h01);
        expectValue("read_row0", SEL_CLAUSE, 160'(16'h0012));
        checkOutput();
        idleInputs(8'h04);
        expectValue("read_row2", SEL_CLAUSE, 160'(16'h0220));
        checkOutput();
        idleInputs(8'h03);
        expectValue("read_or_rows01", SEL_CLAUSE, 160'(16'h005A));
        checkOutput();
        idleInputs(8'h00);
        expectValue("read_none", SEL_CLAUSE, '0);
        expectValue("len_rows012", SEL_LEN, 160'(32'h0000_0222));
        checkOutput();

        // Full row of reserved literals: all eight slots count
        applyStimulus(8'h08, 16'hFFFF, '0, '0, '0, '0, '0, 1'b0);
        tick();
        idleInputs(8'h08);
        expectValue("read_row3_full", SEL_CLAUSE, 160'(16'hFFFF));
        expectValue("len_row3_full", SEL_LEN, 160'(32'h0000_8222));
        checkOutput();

        // Var-state broadcast
        vdata = {NV{ventry}};
        applyStimulus('0, '0, '0, 8'hff, vdata, '0, '0, 1'b0);
        tick();
        idleInputs('0);
        expectValue("vars_broadcast", SEL_VARS, 160'(vdata));
        expectValue("value_broadcast", SEL_VALUE, 160'(16'h5555));
        expectValue("implied_broadcast", SEL_IMPLIED, 160'(8'hff));
        expectValue("assigned_broadcast", SEL_ASSIGN, 160'(8'hff));
        checkOutput();

        // Partial write: only var1 enabled; other slices carry junk that must be ignored
        vdata = {NV{19'h7FFFF}};
        vdata[WVS*1 +: WVS] = '0;
        vexp = {NV{ventry}};
        vexp[WVS*1 +: WVS] = '0;
        applyStimulus('0, '0, '0, 8'h02, vdata, '0, '0, 1'b0);
        tick();
        idleInputs('0);
        expectValue("vars_partial", SEL_VARS, 160'(vexp));
        expectValue("value_partial", SEL_VALUE, 160'(16'h5551));
        expectValue("implied_partial", SEL_IMPLIED, 160'(8'hfd));
        expectValue("assigned_partial", SEL_ASSIGN, 160'(8'hfd));
        checkOutput();

        // Lvl-state load
        applyStimulus('0, '0, '0, '0, '0, 8'hff, {NL{lentry}}, 1'b0);
        tick();
        idleInputs('0);
        expectValue("lvls_load", SEL_LVLS, 160'({NL{lentry}}));
        expectValue("hasbkt_load", SEL_HASBKT, 160'(8'hff));
        checkOutput();

        // Same-cycle read and write of row 0: old value before the edge
        applyStimulus(8'h01, 16'h0003, 8'h01, '0, '0, '0, '0, 1'b0);
        expectValue("rw_same_cycle_old", SEL_CLAUSE, 160'(16'h0012));
        checkOutput();
        tick();
        idleInputs(8'h01);
        expectValue("rw_next_cycle_new", SEL_CLAUSE, 160'(16'h0003));
        expectValue("len_after_rewrite", SEL_LEN, 160'(32'h0000_8221));
        checkOutput();

        // Clear wins over a simultaneous write to every row
        applyStimulus(8'hff, 16'hFFFF, '0, 8'hff, {NV{ventry}}, 8'hff, {NL{lentry}}, 1'b1);
        tick();
        idleInputs(8'hff);
        expectValue("clear_clause", SEL_CLAUSE, '0);
        expectValue("clear_len", SEL_LEN, '0);
        expectValue("clear_vars", SEL_VARS, '0);
        expectValue("clear_lvls", SEL_LVLS, '0);
        checkOutput();

        // Reset mid-load zeroes contents at once, without waiting for an edge
        applyStimulus(8'h10, 16'h0111, '0, 8'h01, {NV{ventry}}, '0, '0, 1'b0);
        tick();
        idleInputs(8'h10);
        expectValue("midload_before_reset", SEL_CLAUSE, 160'(16'h0111));
        checkOutput();
        applyStimulus(8'h20, 16'h0222, 8'h10, '0, '0, '0, '0, 1'b0);
        #1;
        rst = 1'b1;
        #1;
        expectValue("midload_reset_clause", SEL_CLAUSE, '0);
        expectValue("midload_reset_vars", SEL_VARS, '0);
        checkOutput();
        @(negedge clk);
        rst = 1'b0;
        idleInputs(8'h30);
        tick();
        expectValue("after_reset_no_load", SEL_CLAUSE, '0);
        checkOutput();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
